// File: rtl/ready_generator_if.sv
// Bus-side signals of the ready generator: CPU clock strobes, latched address,
// command strobes, external ready and the RDY/BUSY/TIMEOUT_FLAG returns.
interface ready_generator_if;
  logic        cpu_clock_posedge;
  logic        cpu_clock_negedge;
  logic [19:0] ADDRESS;
  logic        ALE;
  logic        IOR_N;
  logic        IOW_N;
  logic        MEMR_N;
  logic        MEMW_N;
  logic        EXT_READY;
  logic        RDY;
  logic        BUSY;
  logic        TIMEOUT_FLAG;

  modport master (
    output cpu_clock_posedge, cpu_clock_negedge, ADDRESS, ALE,
           IOR_N, IOW_N, MEMR_N, MEMW_N, EXT_READY,
    input  RDY, BUSY, TIMEOUT_FLAG
  );

  modport slave (
    input  cpu_clock_posedge, cpu_clock_negedge, ADDRESS, ALE,
           IOR_N, IOW_N, MEMR_N, MEMW_N, EXT_READY,
    output RDY, BUSY, TIMEOUT_FLAG
  );
endinterface

// File: rtl/ready_generator.sv
// Wait-state generator: per-region wait counts, EXT_READY extension, RDY resynchronised
// on the CPU clock falling edge. Define READY_TIMEOUT_EN to add the EXTEND watchdog.
module ready_generator #(
  parameter logic [3:0] IO_WAIT  = 4'd1,
  parameter logic [3:0] MEM_WAIT = 4'd0,
  parameter logic [3:0] ROM_WAIT = 4'd2,
  parameter logic [7:0] TIMEOUT  = 8'd255
) (
  input  logic               clock,
  input  logic               reset,
  ready_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXTEND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic       r_region;
  logic       w_region_nxt;
  logic       r_zero;
  logic       w_zero_nxt;
  logic       r_rdy;
  logic       w_rdy_tgt;

  logic       w_io_req;
  logic       w_mem_req;
  logic       w_any_req;
  logic       w_region_now;
  logic [3:0] w_load;

`ifdef READY_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic [7:0] w_wdog_nxt;
  logic [7:0] w_wdog_inc;
  logic       r_tflag;
  logic       w_tflag_nxt;

  assign w_wdog_inc = r_wdog + 8'd1;
`endif

  assign w_io_req     = ~bus.IOR_N | ~bus.IOW_N;
  assign w_mem_req    = ~bus.MEMR_N | ~bus.MEMW_N;
  assign w_any_req    = w_io_req | w_mem_req;
  assign w_region_now = bus.ALE ? (bus.ADDRESS >= 20'hF0000) : r_region;
  // I/O strobes take priority when both kinds are low together.
  assign w_load       = w_io_req ? IO_WAIT : (w_region_now ? ROM_WAIT : MEM_WAIT);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_region_nxt = r_region;
    w_zero_nxt   = r_zero;
    w_rdy_tgt    = 1'b1;
`ifdef READY_TIMEOUT_EN
    w_wdog_nxt   = r_wdog;
    w_tflag_nxt  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_region_nxt = w_region_now;
        if (w_any_req) begin
          w_count_nxt = w_load;
          w_zero_nxt  = (w_load == 4'd0);
          w_state_nxt = (w_load == 4'd0) ? EXTEND : COUNT;
`ifdef READY_TIMEOUT_EN
          w_wdog_nxt  = '0;
`endif
        end
      end
      COUNT: begin
        w_rdy_tgt = 1'b0;
        if (!w_any_req) begin
          w_state_nxt = IDLE;
        end else if (bus.cpu_clock_posedge) begin
          if (r_count <= 4'd1) begin
            w_count_nxt = '0;
            w_state_nxt = EXTEND;
`ifdef READY_TIMEOUT_EN
            w_wdog_nxt  = '0;
`endif
          end else begin
            w_count_nxt = r_count - 4'd1;
          end
        end
      end
      EXTEND: begin
        // A zero-wait cycle follows EXT_READY directly so RDY never dips when the device is ready.
        w_rdy_tgt = r_zero & bus.EXT_READY;
        if (!w_any_req) begin
          w_state_nxt = IDLE;
        end else if (bus.cpu_clock_posedge) begin
          if (bus.EXT_READY) begin
            w_state_nxt = DONE;
          end
`ifdef READY_TIMEOUT_EN
          else if (w_wdog_inc == TIMEOUT) begin
            w_state_nxt = DONE;
            w_tflag_nxt = 1'b1;
            w_wdog_nxt  = w_wdog_inc;
          end else begin
            w_wdog_nxt  = w_wdog_inc;
          end
`endif
        end
      end
      DONE: begin
        if (!w_any_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_region <= 1'b0;
      r_zero   <= 1'b0;
      r_rdy    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_region <= w_region_nxt;
      r_zero   <= w_zero_nxt;
      if (bus.cpu_clock_negedge) begin
        r_rdy <= w_rdy_tgt;
      end
    end
  end

`ifdef READY_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wdog  <= '0;
      r_tflag <= 1'b0;
    end else begin
      r_wdog  <= w_wdog_nxt;
      r_tflag <= w_tflag_nxt;
    end
  end

  assign bus.TIMEOUT_FLAG = r_tflag;
`else
  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

  assign bus.RDY  = r_rdy;
  assign bus.BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_ready_generator.sv
// Directed bench for ready_generator: default, IO_WAIT=3 and TIMEOUT=10 instances share
// one bus stimulus; one CPU clock is four system clocks (posedge strobe, then negedge strobe).
module tb_ready_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pe, ne, ale, ior_n, iow_n, memr_n, memw_n, ext_rdy;
  logic [19:0] addr;

  int checks = 0;
  int errors = 0;
  int low0, low3, lowt, tflags, glitches;

  always #5 clk = ~clk;

  ready_generator_if bus0 ();
  ready_generator_if bus3 ();
  ready_generator_if bust ();

  assign bus0.cpu_clock_posedge = pe;     assign bus3.cpu_clock_posedge = pe;     assign bust.cpu_clock_posedge = pe;
  assign bus0.cpu_clock_negedge = ne;     assign bus3.cpu_clock_negedge = ne;     assign bust.cpu_clock_negedge = ne;
  assign bus0.ADDRESS = addr;             assign bus3.ADDRESS = addr;             assign bust.ADDRESS = addr;
  assign bus0.ALE = ale;                  assign bus3.ALE = ale;                  assign bust.ALE = ale;
  assign bus0.IOR_N = ior_n;              assign bus3.IOR_N = ior_n;              assign bust.IOR_N = ior_n;
  assign bus0.IOW_N = iow_n;              assign bus3.IOW_N = iow_n;              assign bust.IOW_N = iow_n;
  assign bus0.MEMR_N = memr_n;            assign bus3.MEMR_N = memr_n;            assign bust.MEMR_N = memr_n;
  assign bus0.MEMW_N = memw_n;            assign bus3.MEMW_N = memw_n;            assign bust.MEMW_N = memw_n;
  assign bus0.EXT_READY = ext_rdy;        assign bus3.EXT_READY = ext_rdy;        assign bust.EXT_READY = ext_rdy;

  ready_generator u_dut0 (.clock(clk), .reset(rst_n), .bus(bus0));
  ready_generator #(.IO_WAIT(4'd3)) u_dut3 (.clock(clk), .reset(rst_n), .bus(bus3));
  ready_generator #(.TIMEOUT(8'd10)) u_dutt (.clock(clk), .reset(rst_n), .bus(bust));

  // One system clock; RDY may only move on a negedge-strobe clock while out of reset.
  task automatic sys(input logic p, input logic n);
    logic r0, r3, rt, was_rst;
    r0 = bus0.RDY; r3 = bus3.RDY; rt = bust.RDY; was_rst = rst_n;
    pe = p; ne = n;
    @(posedge clk); #1;
    pe = 1'b0; ne = 1'b0;
    if (was_rst && !n && (bus0.RDY !== r0 || bus3.RDY !== r3 || bust.RDY !== rt)) glitches++;
    if (bust.TIMEOUT_FLAG === 1'b1) tflags++;
  endtask

  task automatic cpu_clk();
    sys(1'b0, 1'b0);
    sys(1'b1, 1'b0);
    sys(1'b0, 1'b0);
    sys(1'b0, 1'b1);
    if (bus0.RDY === 1'b0) low0++;
    if (bus3.RDY === 1'b0) low3++;
    if (bust.RDY === 1'b0) lowt++;
  endtask

  task automatic latch_addr(input logic [19:0] a);
    addr = a; ale = 1'b1;
    sys(1'b0, 1'b0);
    ale = 1'b0;
  endtask

  task automatic release_all();
    ior_n = 1'b1; iow_n = 1'b1; memr_n = 1'b1; memw_n = 1'b1;
    cpu_clk();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sys(1'b0, 1'b0); sys(1'b0, 1'b1);
    rst_n = 1'b1;
    sys(1'b0, 1'b0);
    checks++; if (bus0.RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", bus0.RDY); end
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus0.BUSY); end
    checks++; if (bust.TIMEOUT_FLAG !== 1'b0) begin errors++; $display("FAIL reset_tflag: got %b want 0", bust.TIMEOUT_FLAG); end
  endtask

  task automatic test_io_wait();
    latch_addr(20'h00060);
    ext_rdy = 1'b1; low0 = 0; low3 = 0;
    ior_n = 1'b0;
    repeat (4) cpu_clk();
    checks++; if (low0 !== 1) begin errors++; $display("FAIL io_low_clocks: got %0d want 1", low0); end
    checks++; if (low3 !== 3) begin errors++; $display("FAIL io3_low_clocks: got %0d want 3", low3); end
    checks++; if (bus0.RDY !== 1'b1 || bus0.BUSY !== 1'b1) begin errors++; $display("FAIL io_done_hold: got rdy=%b busy=%b want rdy=1 busy=1", bus0.RDY, bus0.BUSY); end
    release_all();
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL io_release_busy: got %b want 0", bus0.BUSY); end
  endtask

  task automatic test_rom_region();
    latch_addr(20'hFFFF0);
    low0 = 0; memr_n = 1'b0;
    repeat (5) cpu_clk();
    checks++; if (low0 !== 2) begin errors++; $display("FAIL rom_low_clocks: got %0d want 2", low0); end
    checks++; if (bus0.RDY !== 1'b1) begin errors++; $display("FAIL rom_rdy_after: got %b want 1", bus0.RDY); end
    release_all();
    latch_addr(20'h00400);
    low0 = 0; memr_n = 1'b0;
    repeat (3) cpu_clk();
    checks++; if (low0 !== 0) begin errors++; $display("FAIL mem_zero_low_clocks: got %0d want 0", low0); end
    checks++; if (bus0.BUSY !== 1'b1) begin errors++; $display("FAIL mem_zero_busy: got %b want 1", bus0.BUSY); end
    release_all();
  endtask

  task automatic test_ext_wait();
    latch_addr(20'h00060);
    ext_rdy = 1'b0; low0 = 0; glitches = 0;
    iow_n = 1'b0;
    repeat (6) cpu_clk();
    checks++; if (bus0.RDY !== 1'b0 || bus0.BUSY !== 1'b1) begin errors++; $display("FAIL ext_still_waiting: got rdy=%b busy=%b want rdy=0 busy=1", bus0.RDY, bus0.BUSY); end
    ext_rdy = 1'b1;
    cpu_clk();
    checks++; if (bus0.RDY !== 1'b1) begin errors++; $display("FAIL ext_rdy_rise: got %b want 1", bus0.RDY); end
    checks++; if (low0 !== 6) begin errors++; $display("FAIL ext_low_clocks: got %0d want 6", low0); end
    release_all();
    checks++; if (glitches !== 0) begin errors++; $display("FAIL rdy_off_negedge: got %0d changes want 0", glitches); end
  endtask

  task automatic test_timeout();
    latch_addr(20'h00060);
    ext_rdy = 1'b0; low0 = 0; lowt = 0; tflags = 0;
    ior_n = 1'b0;
    repeat (14) cpu_clk();
`ifdef READY_TIMEOUT_EN
    checks++; if (tflags !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", tflags); end
    checks++; if (lowt !== 10) begin errors++; $display("FAIL timeout_low_clocks: got %0d want 10", lowt); end
    checks++; if (bust.RDY !== 1'b1) begin errors++; $display("FAIL timeout_rdy: got %b want 1", bust.RDY); end
`else
    checks++; if (tflags !== 0) begin errors++; $display("FAIL timeout_pulses: got %0d want 0", tflags); end
    checks++; if (lowt !== 14) begin errors++; $display("FAIL timeout_low_clocks: got %0d want 14", lowt); end
    checks++; if (bust.RDY !== 1'b0 || bust.BUSY !== 1'b1) begin errors++; $display("FAIL no_timeout_wait: got rdy=%b busy=%b want rdy=0 busy=1", bust.RDY, bust.BUSY); end
`endif
    checks++; if (low0 !== 14) begin errors++; $display("FAIL long_wait_low_clocks: got %0d want 14", low0); end
    release_all();
    checks++; if (bus0.RDY !== 1'b1 || bus0.BUSY !== 1'b0) begin errors++; $display("FAIL abort_rdy: got rdy=%b busy=%b want rdy=1 busy=0", bus0.RDY, bus0.BUSY); end
    ext_rdy = 1'b1;
  endtask

  task automatic test_io_priority();
    latch_addr(20'hFFFF0);
    low0 = 0;
    ior_n = 1'b0; memr_n = 1'b0;
    repeat (4) cpu_clk();
    checks++; if (low0 !== 1) begin errors++; $display("FAIL io_priority_low_clocks: got %0d want 1", low0); end
    release_all();
  endtask

  task automatic test_reset_mid();
    latch_addr(20'h00060);
    ext_rdy = 1'b1; tflags = 0;
    ior_n = 1'b0;
    cpu_clk();
    checks++; if (bus3.RDY !== 1'b0 || bus3.BUSY !== 1'b1) begin errors++; $display("FAIL mid_before_reset: got rdy=%b busy=%b want rdy=0 busy=1", bus3.RDY, bus3.BUSY); end
    rst_n = 1'b0;
    sys(1'b0, 1'b0);
    checks++; if (bus3.RDY !== 1'b1 || bus3.BUSY !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got rdy=%b busy=%b want rdy=1 busy=0", bus3.RDY, bus3.BUSY); end
    rst_n = 1'b1; ior_n = 1'b1;
    sys(1'b0, 1'b0);
    low3 = 0; ior_n = 1'b0;
    repeat (5) cpu_clk();
    checks++; if (low3 !== 3) begin errors++; $display("FAIL mid_reload_low_clocks: got %0d want 3", low3); end
    checks++; if (tflags !== 0) begin errors++; $display("FAIL mid_reset_tflag: got %0d want 0", tflags); end
    release_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    rst_n = 1'b0; pe = 1'b0; ne = 1'b0; ale = 1'b0; addr = '0;
    ior_n = 1'b1; iow_n = 1'b1; memr_n = 1'b1; memw_n = 1'b1; ext_rdy = 1'b1;
    low0 = 0; low3 = 0; lowt = 0; tflags = 0; glitches = 0;
    @(posedge clk); #1;
    test_reset();
    test_io_wait();
    test_rom_region();
    test_ext_wait();
    test_timeout();
    test_io_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ready_generator.md
READY_GENERATOR -- requirements
Module: ready_generator

Interface
REQ-001 Parameter IO_WAIT, default 4'd1, wait states for I/O cycles.
REQ-002 Parameter MEM_WAIT, default 4'd0, wait states for memory cycles below 20'hF0000.
REQ-003 Parameter ROM_WAIT, default 4'd2, wait states for memory cycles at 20'hF0000-20'hFFFFF.
REQ-004 Parameter TIMEOUT, default 8'd255, maximum cpu_clock_posedge count spent waiting on EXT_READY.
REQ-005 clock  input  1  system clock; one clock domain.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 cpu_clock_posedge  input  1  one-clock strobe at the CPU clock rising edge.
REQ-008 cpu_clock_negedge  input  1  one-clock strobe at the CPU clock falling edge.
REQ-009 ADDRESS  input  20  latched CPU address.
REQ-010 ALE  input  1  address latch enable; high marks the start of a bus cycle.
REQ-011 IOR_N, IOW_N, MEMR_N, MEMW_N  input  1 each  active-low command strobes from the bus arbiter.
REQ-012 EXT_READY  input  1  external device ready; high means ready.
REQ-013 RDY  output  1  ready to the CPU; low inserts wait states.
REQ-014 BUSY  output  1  high while the state is not IDLE.
REQ-015 TIMEOUT_FLAG  output  1  one-clock pulse when the timeout forces ready.

Function
REQ-016 The state machine SHALL use the states IDLE, COUNT, EXTEND and DONE.
REQ-017 In IDLE with ALE high, the block SHALL latch region = (ADDRESS >= 20'hF0000).
REQ-018 In IDLE, on the first clock with any strobe low, the block SHALL load the counter and enter COUNT (or EXTEND if the load value is 0).
- Load value: IO_WAIT for IOR_N/IOW_N; otherwise ROM_WAIT if region is set, else MEM_WAIT.
REQ-019 If an I/O strobe and a memory strobe are low in the same clock, the I/O wait value SHALL be used.
REQ-020 RDY SHALL change only on clocks where cpu_clock_negedge=1, giving 8284-style synchronisation.
REQ-021 In COUNT, RDY SHALL be 0.
- The counter SHALL decrement on each cpu_clock_posedge.
- When the counter reaches 0, the state SHALL go to EXTEND.
REQ-022 In EXTEND, RDY SHALL stay 0 until EXT_READY=1 is sampled on cpu_clock_posedge, then the state SHALL go to DONE.
REQ-023 In DONE, RDY SHALL be 1, and the state SHALL return to IDLE on the first clock with all strobes high.
REQ-024 If all strobes go high in COUNT or EXTEND (aborted cycle), the state SHALL go to IDLE and RDY SHALL return to 1 at the next cpu_clock_negedge.
REQ-025 With a load value of 0 and EXT_READY=1, RDY SHALL never drop for that cycle.
REQ-026 The counter SHALL be 4 bits, SHALL never decrement below 0 and SHALL never wrap.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL set state=IDLE, counter=0, region=0, RDY=1, BUSY=0 and TIMEOUT_FLAG=0.
REQ-028 Reset asserted mid-cycle SHALL abandon the cycle with no TIMEOUT_FLAG pulse.

Configuration
REQ-029 With READY_TIMEOUT_EN defined, an 8-bit watchdog SHALL behave as follows:
- It SHALL clear on entry to EXTEND and increment on each cpu_clock_posedge in EXTEND.
- On reaching TIMEOUT, it SHALL force the state to DONE and pulse TIMEOUT_FLAG for one clock.
REQ-030 Without READY_TIMEOUT_EN, the watchdog SHALL be absent, EXTEND SHALL wait on EXT_READY indefinitely, and TIMEOUT_FLAG SHALL be tied to 0.

Verification
REQ-031 IOR_N low, ADDRESS=20'h00060, EXT_READY=1, defaults -> RDY low for exactly 1 CPU clock, then high until IOR_N rises.
REQ-032 MEMR_N low, ADDRESS=20'hFFFF0 latched by ALE -> RDY low for 2 CPU clocks; MEMR_N low at ADDRESS=20'h00400 -> RDY never low.
REQ-033 IOW_N low, EXT_READY held 0 for 5 CPU clocks -> RDY low for 1+5 CPU clocks, rising at the first cpu_clock_negedge after EXT_READY=1 is sampled.
REQ-034 READY_TIMEOUT_EN, TIMEOUT=8'd10, EXT_READY stuck 0 -> TIMEOUT_FLAG pulses once after 10 CPU clocks in EXTEND, then RDY=1.
REQ-035 reset=0 during COUNT with IO_WAIT=4'd3 -> next clock RDY=1, BUSY=0; the following IOR_N reloads 3.
REQ-036 IOR_N and MEMR_N low together with ROM region set -> IO_WAIT used (1 wait state, not 2).
